seg_to_bin_monitor: RTL and testbench
=====================================

// Module: seg_to_bin_monitor
// PURPOSE
//  Receive-side checker for the 7-segment display interface in the FPGA debug tests.
//  Samples the seven segment lines and waits until the pattern is stable.
//  Decodes the pattern back to a 4-bit value and offers it as a valid/ready beat.
//  Invalid patterns are flagged and counted. Used in benches and on-chip to confirm displayed values.
// PARAMETERS
//  STABLE_CYCLES  4  consecutive sampled cycles a new pattern must hold before it is reported (>=1)
//  CNT_W          8  width of the saturating invalid-pattern counter
// PORTS
//  i_Clk          in   1      main clock (25 MHz)
//  i_Reset        in   1      asynchronous reset, active-high
//  i_Segment_A..G in   1 ea   segment lines; packed internally as {A,B,C,D,E,F,G}, A = bit 6
//  o_Valid        out  1      report beat available
//  i_Ready        in   1      consumer accepts beat
//  o_Binary_Num   out  4      decoded value (0 when o_Error)
//  o_Error        out  1      reported pattern is not a legal hex glyph
//  o_Err_Count    out  CNT_W  number of invalid patterns reported, saturating
// BEHAVIOUR
//  Decode table (pattern->value): 7E->0 30->1 6D->2 79->3 33->4 5B->5 5F->6 70->7
//    7F->8 7B->9 77->A 1F->B 4E->C 3D->D 4F->E 47->F; 7'h00 = blank; anything else = invalid.
//  Reset (async): r_Seg, r_Last, candidate = 7'h00; count = 0; state IDLE; o_Valid = 0;
//    o_Binary_Num = 0; o_Error = 0; o_Err_Count = 0. Outputs drop without waiting for a clock edge.
//  Stage 0: every edge r_Seg <= {A..G}. Only r_Seg feeds the FSM.
//  IDLE: if r_Seg != r_Last -> SETTLE, candidate <= r_Seg, count <= 1.
//  SETTLE, priority order:
//    (1) r_Seg == r_Last -> IDLE (change reverted, nothing reported).
//    (2) r_Seg != candidate -> stay, candidate <= r_Seg, count <= 1.
//    (3) count == STABLE_CYCLES: candidate blank -> r_Last <= candidate, IDLE, no beat;
//        otherwise -> PRESENT, load o_Binary_Num/o_Error from the decode table, o_Valid <= 1.
//        If invalid, o_Err_Count += 1 unless already all-ones.
//    (4) otherwise count <= count + 1.
//  PRESENT: o_Valid = 1; o_Binary_Num and o_Error held constant while !i_Ready.
//    Segment changes are ignored in this state.
//    On i_Ready: r_Last <= candidate, IDLE, o_Valid = 0 on the next cycle. At most one beat per entry.
//  i_Ready while o_Valid = 0 has no effect. A valid&ready cycle completes exactly one transfer.
//  Latency: pins change before edge 1 and are held -> o_Valid = 1 after edge STABLE_CYCLES+2.
//    With defaults this is 6 edges.
//  A new pattern held during PRESENT is detected from IDLE after acceptance.
//    Its latency is then counted from the acceptance edge.
//  Same pattern redisplayed after being reported -> no new beat; an intervening different pattern must settle first.
//  Glitch shorter than STABLE_CYCLES samples -> no beat and no error count.
// TESTING
//  1 Reset, drive 7'h30 for 10 cycles, i_Ready = 1 -> single beat after edge 6: Num = 1, Error = 0; no second beat.
//  2 Sweep all 16 legal codes in table order, 8 cycles each, i_Ready = 1 -> 16 beats with values 0..F in order,
//    o_Err_Count = 0.
//  3 Drive 7E for 2 cycles, then hold 79 -> exactly one beat, Num = 3. Drive 00 for 8 cycles -> no beat.
//  4 Hold 7'h01 -> beat with Error = 1, Num = 0, Err_Count = 1.
//    With CNT_W = 2, alternate 01/02 five times -> Err_Count saturates at 3.
//  5 i_Ready = 0, hold 5B until valid, then switch to 4E -> Num stays 5 until i_Ready = 1.
//    Next beat is Num = C, arriving 6 edges after acceptance.
//  6 Assert i_Reset mid-PRESENT between clock edges -> o_Valid, Num, Error and Err_Count go to 0 immediately.
//    After release, holding the prior pattern yields a fresh beat.

Source files
------------

// File: rtl/seg_to_bin_monitor.sv
// 7-segment receive checker: waits for a stable glyph, decodes it to 4 bits and
// offers it as a valid/ready beat, counting illegal glyphs in a saturating counter.
module seg_to_bin_monitor #(
   parameter int STABLE_CYCLES = 4,
   parameter int CNT_W         = 8
) (
   input  logic             i_Clk,
   input  logic             i_Reset,
   input  logic             i_Segment_A,
   input  logic             i_Segment_B,
   input  logic             i_Segment_C,
   input  logic             i_Segment_D,
   input  logic             i_Segment_E,
   input  logic             i_Segment_F,
   input  logic             i_Segment_G,
   output logic             o_Valid,
   input  logic             i_Ready,
   output logic [3:0]       o_Binary_Num,
   output logic             o_Error,
   output logic [CNT_W-1:0] o_Err_Count
);

   localparam int CW = (STABLE_CYCLES < 1) ? 1 : $clog2(STABLE_CYCLES + 1);

   typedef enum logic [1:0] {IDLE, SETTLE, PRESENT} state_t;

   state_t           state_q, state_d;
   logic [6:0]       seg_q, last_q, last_d, cand_q, cand_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             valid_q, valid_d, err_q, err_d;
   logic [3:0]       num_q, num_d;
   logic [CNT_W-1:0] errcnt_q, errcnt_d;
   logic [4:0]       dec;

   // Returns {invalid, value}; illegal glyphs decode to value 0.
   function automatic logic [4:0] decode(input logic [6:0] s);
      case (s)
         7'h7E: decode = 5'h00;
         7'h30: decode = 5'h01;
         7'h6D: decode = 5'h02;
         7'h79: decode = 5'h03;
         7'h33: decode = 5'h04;
         7'h5B: decode = 5'h05;
         7'h5F: decode = 5'h06;
         7'h70: decode = 5'h07;
         7'h7F: decode = 5'h08;
         7'h7B: decode = 5'h09;
         7'h77: decode = 5'h0A;
         7'h1F: decode = 5'h0B;
         7'h4E: decode = 5'h0C;
         7'h3D: decode = 5'h0D;
         7'h4F: decode = 5'h0E;
         7'h47: decode = 5'h0F;
         default: decode = 5'h10;
      endcase
   endfunction

   assign dec = decode(cand_q);

   always_comb begin
      state_d  = state_q;
      last_d   = last_q;
      cand_d   = cand_q;
      cnt_d    = cnt_q;
      valid_d  = valid_q;
      num_d    = num_q;
      err_d    = err_q;
      errcnt_d = errcnt_q;
      case (state_q)
         IDLE: begin
            if (seg_q != last_q) begin
               state_d = SETTLE;
               cand_d  = seg_q;
               cnt_d   = CW'(1);
            end
         end
         SETTLE: begin
            if (seg_q == last_q) begin
               state_d = IDLE;
            end else if (seg_q != cand_q) begin
               cand_d = seg_q;
               cnt_d  = CW'(1);
            end else if (cnt_q == CW'(STABLE_CYCLES)) begin
               // A settled blank becomes the reference but is never reported.
               if (cand_q == 7'h00) begin
                  last_d  = cand_q;
                  state_d = IDLE;
               end else begin
                  state_d = PRESENT;
                  valid_d = 1'b1;
                  num_d   = dec[3:0];
                  err_d   = dec[4];
                  if (dec[4] && !(&errcnt_q)) errcnt_d = errcnt_q + CNT_W'(1);
               end
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         PRESENT: begin
            if (i_Ready) begin
               last_d  = cand_q;
               state_d = IDLE;
               valid_d = 1'b0;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge i_Clk or posedge i_Reset) begin
      if (i_Reset) begin
         state_q  <= IDLE;
         seg_q    <= 7'h00;
         last_q   <= 7'h00;
         cand_q   <= 7'h00;
         cnt_q    <= '0;
         valid_q  <= 1'b0;
         num_q    <= 4'h0;
         err_q    <= 1'b0;
         errcnt_q <= '0;
      end else begin
         state_q  <= state_d;
         seg_q    <= {i_Segment_A, i_Segment_B, i_Segment_C, i_Segment_D,
                      i_Segment_E, i_Segment_F, i_Segment_G};
         last_q   <= last_d;
         cand_q   <= cand_d;
         cnt_q    <= cnt_d;
         valid_q  <= valid_d;
         num_q    <= num_d;
         err_q    <= err_d;
         errcnt_q <= errcnt_d;
      end
   end

   assign o_Valid      = valid_q;
   assign o_Binary_Num = num_q;
   assign o_Error      = err_q;
   assign o_Err_Count  = errcnt_q;

endmodule

// File: tb/tb_seg_to_bin_monitor.sv
// Directed bench for seg_to_bin_monitor; a second instance with CNT_W = 2
// shares the stimulus to exercise counter saturation.
module tb_seg_to_bin_monitor;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       rdy = 1'b0;
   logic [6:0] seg = 7'h00;
   logic       v, e, v2, e2;
   logic [3:0] n, n2;
   logic [7:0] ec;
   logic [1:0] ec2;
   int         n_cmp = 0;
   int         n_bad = 0;
   int         w;
   logic [4:0] bq[$];
   logic [6:0] tbl[16] = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
                           7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47};

   always #5 clk = ~clk;

   seg_to_bin_monitor dut (
      .i_Clk(clk), .i_Reset(rst),
      .i_Segment_A(seg[6]), .i_Segment_B(seg[5]), .i_Segment_C(seg[4]), .i_Segment_D(seg[3]),
      .i_Segment_E(seg[2]), .i_Segment_F(seg[1]), .i_Segment_G(seg[0]),
      .o_Valid(v), .i_Ready(rdy), .o_Binary_Num(n), .o_Error(e), .o_Err_Count(ec)
   );

   seg_to_bin_monitor #(.STABLE_CYCLES(4), .CNT_W(2)) dut2 (
      .i_Clk(clk), .i_Reset(rst),
      .i_Segment_A(seg[6]), .i_Segment_B(seg[5]), .i_Segment_C(seg[4]), .i_Segment_D(seg[3]),
      .i_Segment_E(seg[2]), .i_Segment_F(seg[1]), .i_Segment_G(seg[0]),
      .o_Valid(v2), .i_Ready(rdy), .o_Binary_Num(n2), .o_Error(e2), .o_Err_Count(ec2)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Records a beat when valid&ready is present ahead of the coming edge, then advances one cycle.
   task automatic tick(input int cycles);
      for (int i = 0; i < cycles; i++) begin
         if (v && rdy) bq.push_back({e, n});
         @(negedge clk);
      end
   endtask

   function automatic logic [4:0] beat(input int i);
      beat = (i < bq.size()) ? bq[i] : 5'h1F;
   endfunction

   initial begin
      #12;
      chk("rst_valid", 32'(v), 32'd0);
      chk("rst_num", 32'(n), 32'd0);
      chk("rst_err", 32'(e), 32'd0);
      chk("rst_errcnt", 32'(ec), 32'd0);
      @(negedge clk);
      rst = 1'b0;

      // Single glyph, ready high
      rdy = 1'b1;
      seg = 7'h30;
      tick(5);
      chk("t1_early", 32'(v), 32'd0);
      tick(1);
      chk("t1_valid", 32'(v), 32'd1);
      chk("t1_num", 32'(n), 32'd1);
      chk("t1_err", 32'(e), 32'd0);
      tick(4);
      chk("t1_nbeats", 32'(bq.size()), 32'd1);
      chk("t1_beat", 32'(beat(0)), 32'h01);

      // Sweep of all legal glyphs
      bq.delete();
      for (int i = 0; i < 16; i++) begin
         seg = tbl[i];
         tick(8);
      end
      chk("t2_nbeats", 32'(bq.size()), 32'd16);
      for (int i = 0; i < 16; i++) chk($sformatf("t2_beat%0d", i), 32'(beat(i)), 32'(i));
      chk("t2_errcnt", 32'(ec), 32'd0);

      // Short glitch then a held glyph; then blank
      bq.delete();
      seg = 7'h7E;
      tick(2);
      seg = 7'h79;
      tick(12);
      chk("t3_nbeats", 32'(bq.size()), 32'd1);
      chk("t3_beat", 32'(beat(0)), 32'h03);
      seg = 7'h00;
      tick(8);
      chk("t3_blank", 32'(bq.size()), 32'd1);

      // Illegal glyphs and counter saturation
      bq.delete();
      seg = 7'h01;
      tick(8);
      chk("t4_beat", 32'(beat(0)), 32'h10);
      chk("t4_errcnt", 32'(ec), 32'd1);
      for (int k = 0; k < 5; k++) begin
         seg = (k % 2 == 0) ? 7'h02 : 7'h01;
         tick(8);
         chk($sformatf("t4_cnt8_%0d", k), 32'(ec), 32'(k + 2));
         chk($sformatf("t4_cnt2_%0d", k), 32'(ec2), (k + 2 > 3) ? 32'd3 : 32'(k + 2));
      end

      // Back-pressure: held beat ignores segment changes
      bq.delete();
      rdy = 1'b0;
      seg = 7'h5B;
      w = 0;
      while (!v && w < 20) begin
         tick(1);
         w++;
      end
      chk("t5_latency", 32'(w), 32'd6);
      chk("t5_num", 32'(n), 32'd5);
      seg = 7'h4E;
      tick(5);
      chk("t5_hold_valid", 32'(v), 32'd1);
      chk("t5_hold_num", 32'(n), 32'd5);
      chk("t5_hold_err", 32'(e), 32'd0);
      rdy = 1'b1;
      tick(1);
      rdy = 1'b0;
      chk("t5_accept", 32'(v), 32'd0);
      chk("t5_beat", 32'(beat(0)), 32'h05);
      tick(4);
      chk("t5_next_early", 32'(v), 32'd0);
      tick(1);
      chk("t5_next_valid", 32'(v), 32'd1);
      chk("t5_next_num", 32'(n), 32'hC);

      // Asynchronous reset while presenting
      #2;
      rst = 1'b1;
      #1;
      chk("t6_valid", 32'(v), 32'd0);
      chk("t6_num", 32'(n), 32'd0);
      chk("t6_err", 32'(e), 32'd0);
      chk("t6_errcnt", 32'(ec), 32'd0);
      chk("t6_errcnt2", 32'(ec2), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      bq.delete();
      tick(5);
      chk("t6_early", 32'(v), 32'd0);
      tick(1);
      chk("t6_valid_again", 32'(v), 32'd1);
      chk("t6_num_again", 32'(n), 32'hC);
      rdy = 1'b1;
      tick(1);
      chk("t6_beat", 32'(beat(0)), 32'h0C);
      chk("t6_nbeats", 32'(bq.size()), 32'd1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
